// File: rtl/score_pkg.sv
// Shared widths and FSM encoding for the post-game score-check responder.
package score_pkg;
    localparam int ID_W        = 3;
    localparam int SCORE_W     = 7;
    localparam int NUM_PLAYERS = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/score_table.sv
// Per-player personal-best register file: one write port, one combinational
// compare read port and one registered display read port.
module score_table #(
    parameter int ID_W        = 3,
    parameter int SCORE_W     = 7,
    parameter int NUM_PLAYERS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [ID_W-1:0]    wr_id_i,
    input  logic [SCORE_W-1:0] wr_score_i,
    input  logic [ID_W-1:0]    cmp_id_i,
    output logic [SCORE_W-1:0] cmp_score_o,
    input  logic [ID_W-1:0]    rd_id_i,
    output logic [SCORE_W-1:0] rd_score_o
);
    logic [SCORE_W-1:0] mem_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] rd_q;

    // The display port samples the table before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[wr_id_i] <= wr_score_i;
            end
            rd_q <= mem_q[rd_id_i];
        end
    end

    assign cmp_score_o = mem_q[cmp_id_i];
    assign rd_score_o  = rd_q;
endmodule

// File: rtl/score_tracker.sv
// Score-check responder: compares a submitted score with the player's personal
// best and the global best, updates the records and pulses valid.
module score_tracker
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS = score_pkg::NUM_PLAYERS,
    parameter int ID_W        = score_pkg::ID_W,
    parameter int SCORE_W     = score_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_req,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [ID_W-1:0]    intPlayID_in,
    input  logic               isGuest_in,
    input  logic [ID_W-1:0]    rd_id,
    output logic               valid,
    output logic               personalwin,
    output logic               globalwin,
    output logic               busy,
    output logic [SCORE_W-1:0] rd_score,
    output logic [SCORE_W-1:0] global_best,
    output logic [ID_W-1:0]    global_id,
    output logic               global_guest,
    output state_t             fsm_state
);
    // Handshake: a request is taken only when score_req is high in IDLE; the
    // response is valid high for one cycle, and personalwin/globalwin are held
    // until the next comparison so the initiator can sample them afterwards.
    state_t             state_q;
    logic [SCORE_W-1:0] score_q;
    logic [ID_W-1:0]    id_q;
    logic               guest_q;
    logic               valid_q, pw_q, gw_q;
    logic [SCORE_W-1:0] gbest_q;
    logic [ID_W-1:0]    gid_q;
    logic               gguest_q;

    logic [SCORE_W-1:0] personal_best;
    logic               pw_d, gw_d, table_we;

    // Strict compares: a tie never wins, so a score of 0 never wins.
    assign pw_d     = !guest_q && (score_q > personal_best);
    assign gw_d     = score_q > gbest_q;
    assign table_we = (state_q == CMP) && pw_d;

    score_table #(
        .ID_W       (ID_W),
        .SCORE_W    (SCORE_W),
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .we_i       (table_we),
        .wr_id_i    (id_q),
        .wr_score_i (score_q),
        .cmp_id_i   (id_q),
        .cmp_score_o(personal_best),
        .rd_id_i    (rd_id),
        .rd_score_o (rd_score)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            score_q  <= '0;
            id_q     <= '0;
            guest_q  <= 1'b0;
            valid_q  <= 1'b0;
            pw_q     <= 1'b0;
            gw_q     <= 1'b0;
            gbest_q  <= '0;
            gid_q    <= '0;
            gguest_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (score_req) begin
                        score_q <= score_in;
                        id_q    <= intPlayID_in;
                        guest_q <= isGuest_in;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    pw_q <= pw_d;
                    gw_q <= gw_d;
                    if (gw_d) begin
                        gbest_q  <= score_q;
                        gid_q    <= id_q;
                        gguest_q <= guest_q;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid        = valid_q;
    assign personalwin  = pw_q;
    assign globalwin    = gw_q;
    assign busy         = (state_q != IDLE);
    assign global_best  = gbest_q;
    assign global_id    = gid_q;
    assign global_guest = gguest_q;
    assign fsm_state    = state_q;
endmodule
